// File: rtl/color_quan_ctrl.sv
// Frame-synchronous style sequencer plus 2-stage per-channel colour quantizer, 1 pixel/clk, no backpressure.
// Optional GRAY style (mode 4, 3-bit mode encoding) enabled by defining COLOR_QUAN_GRAY_EN.
module color_quan_ctrl #(
  parameter logic [1:0] DEFAULT_MODE = 2'd1,
  parameter logic [7:0] SAT_VAL      = 8'd255
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iMODE_NEXT,
  input  logic       iFRAME_START,
  input  logic       iDVAL,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic       oDVAL,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
`ifdef COLOR_QUAN_GRAY_EN
  output logic [2:0] oMODE,
`else
  output logic [1:0] oMODE,
`endif
  output logic       oPEND
);

`ifdef COLOR_QUAN_GRAY_EN
  localparam int MW = 3;
`else
  localparam int MW = 2;
`endif

  typedef enum logic [MW-1:0] {
    BYPASS,
    QUANT8,
    QUANT4,
`ifdef COLOR_QUAN_GRAY_EN
    POSTER,
    GRAY
`else
    POSTER
`endif
  } mode_t;

`ifdef COLOR_QUAN_GRAY_EN
  localparam mode_t RST_MODE = mode_t'({1'b0, DEFAULT_MODE});
`else
  localparam mode_t RST_MODE = mode_t'(DEFAULT_MODE);
`endif

  mode_t      pend_q, pend_d;
  mode_t      act_q, act_d;
  logic       pend_flag_q;

  logic       s1_vld_q;
  logic [7:0] s1_r_q, s1_g_q, s1_b_q;
  mode_t      s1_mode_q;

  logic       dval_q;
  logic [7:0] r_q, g_q, b_q;
  logic [7:0] r_d, g_d, b_d;

  // Upper bound of the bucket holding v; a bound of 256 saturates.
  function automatic logic [7:0] bucket(input logic [7:0] v, input logic coarse);
    logic [8:0] r;
    if (coarse) r = (({1'b0, v} >> 6) + 9'd1) << 6;
    else        r = (({1'b0, v} >> 5) + 9'd1) << 5;
    bucket = r[8] ? SAT_VAL : r[7:0];
  endfunction

  function automatic logic [7:0] quant(input mode_t m, input logic [7:0] v);
    case (m)
      QUANT8:  quant = bucket(v, 1'b0);
      QUANT4:  quant = bucket(v, 1'b1);
      POSTER:  quant = (v >= 8'd128) ? 8'hFF : 8'h00;
      default: quant = v;
    endcase
  endfunction

  always_comb begin
    pend_d = pend_q;
    if (iMODE_NEXT) begin
      case (pend_q)
        BYPASS:  pend_d = QUANT8;
        QUANT8:  pend_d = QUANT4;
        QUANT4:  pend_d = POSTER;
`ifdef COLOR_QUAN_GRAY_EN
        POSTER:  pend_d = GRAY;
`endif
        default: pend_d = BYPASS;
      endcase
    end
    // Commit takes the pending value from before this edge, so a same-cycle press lands next frame.
    act_d = iFRAME_START ? pend_q : act_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pend_q      <= RST_MODE;
      act_q       <= RST_MODE;
      pend_flag_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_flag_q <= (pend_d != act_d);
    end
  end

  // Stage 1: capture pixel together with the mode in force for it (act_d covers same-cycle commit).
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_vld_q  <= 1'b0;
      s1_r_q    <= 8'd0;
      s1_g_q    <= 8'd0;
      s1_b_q    <= 8'd0;
      s1_mode_q <= RST_MODE;
    end else begin
      s1_vld_q  <= iDVAL;
      s1_r_q    <= iR;
      s1_g_q    <= iG;
      s1_b_q    <= iB;
      s1_mode_q <= act_d;
    end
  end

`ifdef COLOR_QUAN_GRAY_EN
  logic [9:0] gsum;
  logic [7:0] gray_y;
  always_comb begin
    gsum   = {2'b00, s1_r_q} + {1'b0, s1_g_q, 1'b0} + {2'b00, s1_b_q};
    gray_y = 8'(gsum >> 2);
  end
`endif

  always_comb begin
    r_d = quant(s1_mode_q, s1_r_q);
    g_d = quant(s1_mode_q, s1_g_q);
    b_d = quant(s1_mode_q, s1_b_q);
`ifdef COLOR_QUAN_GRAY_EN
    if (s1_mode_q == GRAY) begin
      r_d = bucket(gray_y, 1'b0);
      g_d = r_d;
      b_d = r_d;
    end
`endif
  end

  // Stage 2: outputs only move on a valid pixel, otherwise they hold.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dval_q <= 1'b0;
      r_q    <= 8'd0;
      g_q    <= 8'd0;
      b_q    <= 8'd0;
    end else begin
      dval_q <= s1_vld_q;
      if (s1_vld_q) begin
        r_q <= r_d;
        g_q <= g_d;
        b_q <= b_d;
      end
    end
  end

  assign oDVAL = dval_q;
  assign oR    = r_q;
  assign oG    = g_q;
  assign oB    = b_q;
  assign oMODE = act_q;
  assign oPEND = pend_flag_q;

endmodule
